pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central sequencer for the four pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Generates per-buffer write enables, flushes and the shared read enable.
- Resolves load-use hazards, taken-branch flushes, multi-cycle mul/div stalls and variable-latency memory stalls, with a memory timeout and a stall-cycle counter.

Parameters:
REG_ADDR_W, 4, register-specifier width.
MULDIV_CYCLES, 4, total EX occupancy of a mul/div op in cycles (>=2).
MEM_TIMEOUT, 15, max cycles spent in MEM_WAIT before forced release (>=1).

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous reset, active-low.
ID_EX_MEM_READ  in  1  instruction in EX is a load.
ID_EX_DEST  in  REG_ADDR_W  destination register of EX instruction.
IF_ID_SRC1  in  REG_ADDR_W  source 1 of ID instruction.
IF_ID_SRC2  in  REG_ADDR_W  source 2 of ID instruction.
EX_MULDIV_START  in  1  mul/div entering EX this cycle.
BRANCH_TAKEN  in  1  branch resolved taken in EX.
MEM_REQ  in  1  EX/MEM holds a memory access.
MEM_READY  in  1  memory completes the access this cycle.
PC_WRITE  out  1  PC load enable.
IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE, MEM_WB_WRITE  out  1 each  buffer WRITE_ENABLE.
IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH  out  1 each  load bubble (zeros) instead of inputs.
BUF_READ_ENABLE  out  1  shared READ_ENABLE of all buffers.
MEM_ERROR  out  1  sticky memory-timeout flag.
STALL_COUNT  out  16  cycles with PC_WRITE=0 since reset, saturating.

Behaviour:
- States: INIT, RUN, MULDIV, MEM_WAIT. Registered state, countdown (muldiv), wait counter, MEM_ERROR, STALL_COUNT. Control outputs are combinational from state plus inputs.
- RST low: state=INIT, counters=0, MEM_ERROR=0, STALL_COUNT=0. Outputs in INIT: all four *_WRITE=1, all four *_FLUSH=1, PC_WRITE=0, BUF_READ_ENABLE=0.
- INIT lasts exactly one cycle after RST rises, then RUN. This clears every buffer. INIT cycles are not counted in STALL_COUNT.
- BUF_READ_ENABLE=1 in all states except INIT.
- RUN default: all *_WRITE=1, all *_FLUSH=0. Conditions are evaluated in priority order; the first match wins.
  1. Mem stall (MEM_REQ & !MEM_READY):
     - PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE = 0.
     - MEM_WB_FLUSH=1.
     - Next state MEM_WAIT; wait counter=1.
     - Any branch or hazard present this cycle is ignored; it is re-evaluated when the pipe unfreezes.
  2. EX_MULDIV_START:
     - PC_WRITE, IF_ID_WRITE, ID_EX_WRITE = 0.
     - EX_MEM_FLUSH=1.
     - Countdown loaded with MULDIV_CYCLES-2; next state MULDIV.
     - BRANCH_TAKEN is ignored.
  3. BRANCH_TAKEN: IF_ID_FLUSH=1, ID_EX_FLUSH=1; all writes stay 1 (PC loads the target).
  4. Load-use: ID_EX_MEM_READ & ID_EX_DEST!=0 & (ID_EX_DEST==IF_ID_SRC1 | ID_EX_DEST==IF_ID_SRC2):
     - PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1.
     - Exactly one bubble per hazard.
- MEM_WAIT:
  - Outputs are the same freeze as the mem stall.
  - If MEM_READY=1: all writes 1, no flushes, next RUN.
  - Else if wait counter==MEM_TIMEOUT: set MEM_ERROR, release as if ready, next RUN.
  - Otherwise the wait counter increments.
- MULDIV:
  - Outputs are the same freeze as in EX_MULDIV_START.
  - If a mem stall is present: apply the mem-stall freeze, and the countdown pauses (MULDIV state held).
  - Else if countdown==0: all writes 1, no flushes (result captured into EX/MEM), next RUN.
  - Otherwise the countdown decrements.
  - Total PC freeze without memory stalls = MULDIV_CYCLES-1 cycles; the capture cycle is the MULDIV_CYCLES-th EX cycle.
- STALL_COUNT:
  - Increments on each clock edge where the state is not INIT and PC_WRITE was 0.
  - Holds at 16'hFFFF.
- MEM_ERROR is cleared only by reset.
- Reset asserted mid-stall immediately forces INIT outputs; no partial state survives.

Test Plan:
- Reset, release: 1 cycle all flushes=1 and PC_WRITE=0, then RUN with all writes=1, BUF_READ_ENABLE=1, STALL_COUNT=0.
- Load-use: ID_EX_MEM_READ=1, DEST=3, SRC2=3 for one cycle -> PC_WRITE=0, IF_ID_WRITE=0, ID_EX_FLUSH=1 that cycle, STALL_COUNT=1. Repeat with DEST=0 -> no stall.
- MULDIV_CYCLES=4: pulse EX_MULDIV_START -> PC frozen 3 cycles, EX_MEM_FLUSH=1 on those cycles, 4th EX cycle EX_MEM_WRITE=1 with no flush, STALL_COUNT=3.
- Memory: MEM_REQ=1, MEM_READY low 5 cycles then high -> EX_MEM_WRITE=0 and MEM_WB_FLUSH=1 for 5 cycles, released on READY cycle, MEM_ERROR=0.
- Timeout: MEM_READY held low, MEM_TIMEOUT=15 -> forced release, MEM_ERROR=1 sticky until RST low.
- Simultaneous BRANCH_TAKEN with load-use -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_WRITE=1. Simultaneous mem stall with branch -> freeze only, branch flush applied after release.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and its sequencer.
// master = sequencer (drives enables/flushes), slave = datapath (drives hazard/status inputs).
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_W = 4
);
    logic                  ID_EX_MEM_READ;
    logic [REG_ADDR_W-1:0] ID_EX_DEST;
    logic [REG_ADDR_W-1:0] IF_ID_SRC1;
    logic [REG_ADDR_W-1:0] IF_ID_SRC2;
    logic                  EX_MULDIV_START;
    logic                  BRANCH_TAKEN;
    logic                  MEM_REQ;
    logic                  MEM_READY;

    logic                  PC_WRITE;
    logic                  IF_ID_WRITE;
    logic                  ID_EX_WRITE;
    logic                  EX_MEM_WRITE;
    logic                  MEM_WB_WRITE;
    logic                  IF_ID_FLUSH;
    logic                  ID_EX_FLUSH;
    logic                  EX_MEM_FLUSH;
    logic                  MEM_WB_FLUSH;
    logic                  BUF_READ_ENABLE;
    logic                  MEM_ERROR;
    logic [15:0]           STALL_COUNT;

    modport master (
        input  ID_EX_MEM_READ, ID_EX_DEST, IF_ID_SRC1, IF_ID_SRC2,
               EX_MULDIV_START, BRANCH_TAKEN, MEM_REQ, MEM_READY,
        output PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE, MEM_WB_WRITE,
               IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH,
               BUF_READ_ENABLE, MEM_ERROR, STALL_COUNT
    );

    modport slave (
        output ID_EX_MEM_READ, ID_EX_DEST, IF_ID_SRC1, IF_ID_SRC2,
               EX_MULDIV_START, BRANCH_TAKEN, MEM_REQ, MEM_READY,
        input  PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE, MEM_WB_WRITE,
               IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MEM_WB_FLUSH,
               BUF_READ_ENABLE, MEM_ERROR, STALL_COUNT
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: buffer enables/flushes are combinational from state+inputs (zero latency).
// Stalls freeze upstream buffers; memory waits are bounded by MEM_TIMEOUT and flagged in MEM_ERROR.
module pipeline_ctrl #(
    parameter int REG_ADDR_W    = 4,
    parameter int MULDIV_CYCLES = 4,
    parameter int MEM_TIMEOUT   = 15
) (
    input  logic              CLK,
    input  logic              RST,
    pipeline_ctrl_if.master   bus
);

    localparam int CD_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES - 1) : 1;
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MULDIV   = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    state_t          state;
    logic [CD_W-1:0] md_cnt;
    logic [WC_W-1:0] wait_cnt;
    logic            mem_error;
    logic [15:0]     stall_cnt;

    logic mem_stall;
    logic load_use;
    logic wait_expired;
    logic in_init;

    logic mem_freeze;
    logic md_freeze;
    logic br_flush;
    logic lu_bubble;

    logic pc_write;

    assign mem_stall    = bus.MEM_REQ && !bus.MEM_READY;
    assign load_use     = bus.ID_EX_MEM_READ && (bus.ID_EX_DEST != REG_ZERO) &&
                          ((bus.ID_EX_DEST == bus.IF_ID_SRC1) || (bus.ID_EX_DEST == bus.IF_ID_SRC2));
    assign wait_expired = (wait_cnt == WC_W'(MEM_TIMEOUT));
    assign in_init      = (state == INIT);

    // First matching condition wins; lower-priority events are dropped, not queued.
    always_comb begin
        mem_freeze = 1'b0;
        md_freeze  = 1'b0;
        br_flush   = 1'b0;
        lu_bubble  = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall)                mem_freeze = 1'b1;
                else if (bus.EX_MULDIV_START) md_freeze  = 1'b1;
                else if (bus.BRANCH_TAKEN)    br_flush   = 1'b1;
                else if (load_use)            lu_bubble  = 1'b1;
            end
            MULDIV: begin
                if (mem_stall)               mem_freeze = 1'b1;
                else if (md_cnt != '0)       md_freeze  = 1'b1;
            end
            MEM_WAIT: begin
                if (!bus.MEM_READY && !wait_expired) mem_freeze = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write             = !in_init && !mem_freeze && !md_freeze && !lu_bubble;
    assign bus.PC_WRITE         = pc_write;
    assign bus.IF_ID_WRITE      = !mem_freeze && !md_freeze && !lu_bubble;
    assign bus.ID_EX_WRITE      = !mem_freeze && !md_freeze;
    assign bus.EX_MEM_WRITE     = !mem_freeze;
    assign bus.MEM_WB_WRITE     = 1'b1;
    assign bus.IF_ID_FLUSH      = in_init || br_flush;
    assign bus.ID_EX_FLUSH      = in_init || br_flush || lu_bubble;
    assign bus.EX_MEM_FLUSH     = in_init || md_freeze;
    assign bus.MEM_WB_FLUSH     = in_init || mem_freeze;
    assign bus.BUF_READ_ENABLE  = !in_init;
    assign bus.MEM_ERROR        = mem_error;
    assign bus.STALL_COUNT      = stall_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= INIT;
            md_cnt    <= '0;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (!in_init && !pc_write && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;

            case (state)
                INIT: state <= RUN;
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end else if (bus.EX_MULDIV_START) begin
                        state  <= MULDIV;
                        md_cnt <= CD_W'(MULDIV_CYCLES - 2);
                    end
                end
                MULDIV: begin
                    // A memory stall pauses the mul/div countdown.
                    if (!mem_stall) begin
                        if (md_cnt == '0) state  <= RUN;
                        else              md_cnt <= md_cnt - CD_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (bus.MEM_READY) begin
                        state <= RUN;
                    end else if (wait_expired) begin
                        mem_error <= 1'b1;
                        state     <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, timeout/reset sequences, then random
// traffic checked against a cycle-count reference model.
module tb_pipeline_ctrl;

    localparam int MULDIV_CYCLES = 4;
    localparam int MEM_TIMEOUT   = 15;

    // {PC, W_IFID, W_IDEX, W_EXMEM, W_MEMWB, F_IFID, F_IDEX, F_EXMEM, F_MEMWB, RD}
    localparam logic [9:0] O_INIT = 10'b0_1111_1111_0;
    localparam logic [9:0] O_RUN  = 10'b1_1111_0000_1;
    localparam logic [9:0] O_LU   = 10'b0_0111_0100_1;
    localparam logic [9:0] O_MD   = 10'b0_0011_0010_1;
    localparam logic [9:0] O_MEM  = 10'b0_0001_0001_1;
    localparam logic [9:0] O_BR   = 10'b1_1111_1100_1;

    typedef struct packed {
        logic       mr;
        logic [3:0] dest;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       start;
        logic       br;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] exp;
        int         stall;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    pipeline_ctrl_if #(.REG_ADDR_W(4)) bus ();

    pipeline_ctrl #(
        .REG_ADDR_W   (4),
        .MULDIV_CYCLES(MULDIV_CYCLES),
        .MEM_TIMEOUT  (MEM_TIMEOUT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: counts of cycles spent in each kind of wait.
    int m_init, m_wait, m_md, m_err, m_stall;
    in_t cur;
    vec_t tbl[$];

    function automatic in_t mk(logic mr, logic [3:0] dest, logic [3:0] s1, logic [3:0] s2,
                               logic start, logic br, logic req, logic rdy);
        in_t i;
        i.mr = mr; i.dest = dest; i.s1 = s1; i.s2 = s2;
        i.start = start; i.br = br; i.req = req; i.rdy = rdy;
        return i;
    endfunction

    function automatic logic [9:0] dut_vec();
        return {bus.PC_WRITE, bus.IF_ID_WRITE, bus.ID_EX_WRITE, bus.EX_MEM_WRITE, bus.MEM_WB_WRITE,
                bus.IF_ID_FLUSH, bus.ID_EX_FLUSH, bus.EX_MEM_FLUSH, bus.MEM_WB_FLUSH,
                bus.BUF_READ_ENABLE};
    endfunction

    function automatic logic [9:0] model_out(in_t i);
        bit memstall = i.req && !i.rdy;
        bit lu = i.mr && (i.dest != 4'd0) && ((i.dest == i.s1) || (i.dest == i.s2));
        if (m_init != 0) return O_INIT;
        if (m_wait > 0) return (i.rdy || m_wait >= MEM_TIMEOUT) ? O_RUN : O_MEM;
        if (m_md > 0) begin
            if (memstall) return O_MEM;
            return (m_md + 1 == MULDIV_CYCLES) ? O_RUN : O_MD;
        end
        if (memstall) return O_MEM;
        if (i.start)  return O_MD;
        if (i.br)     return O_BR;
        if (lu)       return O_LU;
        return O_RUN;
    endfunction

    task automatic model_reset();
        m_init = 1; m_wait = 0; m_md = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic model_step(in_t i);
        logic [9:0] o;
        bit memstall;
        o = model_out(i);
        memstall = i.req && !i.rdy;
        if (m_init == 0 && !o[9] && m_stall < 65535) m_stall++;
        if (m_init != 0) m_init = 0;
        else if (m_wait > 0) begin
            if (i.rdy) m_wait = 0;
            else if (m_wait >= MEM_TIMEOUT) begin m_err = 1; m_wait = 0; end
            else m_wait++;
        end else if (m_md > 0) begin
            if (!memstall) m_md = (m_md + 1 == MULDIV_CYCLES) ? 0 : m_md + 1;
        end else if (memstall) m_wait = 1;
        else if (i.start) m_md = 1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(in_t i);
        cur = i;
        bus.ID_EX_MEM_READ  = i.mr;
        bus.ID_EX_DEST      = i.dest;
        bus.IF_ID_SRC1      = i.s1;
        bus.IF_ID_SRC2      = i.s2;
        bus.EX_MULDIV_START = i.start;
        bus.BRANCH_TAKEN    = i.br;
        bus.MEM_REQ         = i.req;
        bus.MEM_READY       = i.rdy;
    endtask

    task automatic apply(in_t i);
        @(negedge CLK);
        drive(i);
        #1;
    endtask

    task automatic finish_cycle();
        @(posedge CLK);
        model_step(cur);
    endtask

    task automatic chk_model(string name);
        chk({name, "_vec"},   32'(dut_vec()),        32'(model_out(cur)));
        chk({name, "_stall"}, 32'(bus.STALL_COUNT),  m_stall);
        chk({name, "_err"},   32'(bus.MEM_ERROR),    m_err);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        model_reset();
        #1;
        chk("rst_vec",   32'(dut_vec()),       32'(O_INIT));
        chk("rst_stall", 32'(bus.STALL_COUNT), 32'd0);
        chk("rst_err",   32'(bus.MEM_ERROR),   32'd0);
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b1;
    endtask

    task automatic add(in_t i, logic [9:0] e, int s);
        vec_t v;
        v.in = i; v.exp = e; v.stall = s;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        in_t idle, ms, r;
        idle = '0;
        ms   = mk(0, 0, 0, 0, 0, 0, 1, 0);
        drive(idle);

        // Directed table: inputs, expected controls, STALL_COUNT seen that cycle.
        add(idle,                           O_INIT, 0);
        add(idle,                           O_RUN,  0);
        add(mk(1, 3, 5, 3, 0, 0, 0, 0),     O_LU,   0);
        add(idle,                           O_RUN,  1);
        add(mk(1, 0, 0, 0, 0, 0, 0, 0),     O_RUN,  1);
        add(mk(1, 3, 3, 0, 0, 1, 0, 0),     O_BR,   1);
        add(idle,                           O_RUN,  1);
        add(mk(0, 0, 0, 0, 1, 0, 0, 0),     O_MD,   1);
        add(idle,                           O_MD,   2);
        add(idle,                           O_MD,   3);
        add(idle,                           O_RUN,  4);
        add(idle,                           O_RUN,  4);
        for (int k = 0; k < 5; k++)
            add(mk(0, 0, 0, 0, 0, 1, 1, 0), O_MEM,  4 + k);
        add(mk(0, 0, 0, 0, 0, 1, 1, 1),     O_RUN,  9);
        add(mk(0, 0, 0, 0, 0, 1, 0, 0),     O_BR,   9);
        add(idle,                           O_RUN,  9);
        add(mk(0, 0, 0, 0, 1, 1, 0, 0),     O_MD,   9);
        add(ms,                             O_MEM,  10);
        add(idle,                           O_MD,   11);
        add(idle,                           O_MD,   12);
        add(idle,                           O_RUN,  13);
        add(idle,                           O_RUN,  13);

        do_reset();
        foreach (tbl[k]) begin
            apply(tbl[k].in);
            chk($sformatf("tbl%0d_vec", k),   32'(dut_vec()),       32'(tbl[k].exp));
            chk($sformatf("tbl%0d_stall", k), 32'(bus.STALL_COUNT), tbl[k].stall);
            chk($sformatf("tbl%0d_err", k),   32'(bus.MEM_ERROR),   32'd0);
            chk_model($sformatf("tbl%0d_model", k));
            finish_cycle();
        end

        // Memory timeout: ready never arrives.
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            apply(ms);
            chk("timeout_freeze", 32'(dut_vec()), 32'(O_MEM));
            finish_cycle();
        end
        apply(ms);
        chk("timeout_release", 32'(dut_vec()),       32'(O_RUN));
        chk("timeout_err_pre", 32'(bus.MEM_ERROR),   32'd0);
        chk("timeout_stall",   32'(bus.STALL_COUNT), 32'd28);
        finish_cycle();
        for (int k = 0; k < 4; k++) begin
            apply(idle);
            chk("err_sticky", 32'(bus.MEM_ERROR), 32'd1);
            chk_model("post_timeout");
            finish_cycle();
        end

        // Reset asserted in the middle of a memory stall.
        apply(ms);
        finish_cycle();
        apply(ms);
        chk("midstall_vec", 32'(dut_vec()), 32'(O_MEM));
        RST = 1'b0;
        #1;
        chk("midrst_vec",   32'(dut_vec()),       32'(O_INIT));
        chk("midrst_stall", 32'(bus.STALL_COUNT), 32'd0);
        chk("midrst_err",   32'(bus.MEM_ERROR),   32'd0);
        model_reset();
        drive(idle);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        apply(idle);
        chk("rerst_init", 32'(dut_vec()), 32'(O_INIT));
        finish_cycle();
        apply(idle);
        chk("rerst_run", 32'(dut_vec()), 32'(O_RUN));
        finish_cycle();

        // Random traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            r.mr    = 1'($urandom_range(0, 1));
            r.dest  = 4'($urandom_range(0, 3));
            r.s1    = 4'($urandom_range(0, 3));
            r.s2    = 4'($urandom_range(0, 3));
            r.start = ($urandom_range(0, 9) == 0);
            r.br    = ($urandom_range(0, 3) == 0);
            r.req   = ($urandom_range(0, 2) == 0);
            r.rdy   = ($urandom_range(0, 5) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            apply(r);
            chk_model($sformatf("rnd%0d", n));
            finish_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
